// File: rtl/pwm_gen_synch.sv
// PWM generator driven by an upstream tick, with a double-buffered period/duty configuration.
// Latency: pwm_out, cnt and period_end are registered and update on the same edge; pwm_out tracks cnt with zero lag.
// Backpressure: cfg_ready drops while a shadow configuration is pending; the producer holds cfg_valid until it is accepted.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   tick                 count enable from the upstream counter stage
//   start, stop          one-cycle run / stop-at-period-end requests (stop wins when both are high)
//   cfg_valid/cfg_ready  configuration handshake carrying cfg_period (P, period = P+1 ticks) and cfg_duty (D)
//   pwm_out              PWM waveform, active while cnt < D
//   cnt                  current period count
//   period_end           one-cycle pulse after each wrap from P to 0
//   busy                 high while running or finishing the last period
//
// Optional feature: define PWM_ACTIVE_LOW_EN to invert pwm_out (idle/reset level becomes 1).

module pwm_gen_synch #(
   parameter int BITS = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tick,
   input  logic            start,
   input  logic            stop,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [BITS-1:0] cfg_period,
   input  logic [BITS-1:0] cfg_duty,
   output logic            pwm_out,
   output logic [BITS-1:0] cnt,
   output logic            period_end,
   output logic            busy
);

`ifdef PWM_ACTIVE_LOW_EN
   localparam logic PWM_IDLE = 1'b1;
`else
   localparam logic PWM_IDLE = 1'b0;
`endif

   localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STOPPING
   } state_t;

   state_t          state, state_nxt;
   logic [BITS-1:0] per_act, duty_act;
   logic [BITS-1:0] per_sh, duty_sh;
   logic [BITS-1:0] per_nxt, duty_nxt, cnt_nxt;
   logic            pending;
   logic            running, wrap, xfer, apply, pwm_nxt;

   always_comb begin
      running   = (state != S_IDLE);
      wrap      = running && tick && (cnt == per_act);
      // xfer and apply are exclusive: one needs pending low, the other pending high.
      xfer      = cfg_valid && !pending;
      apply     = pending && (!running || wrap);
      per_nxt   = apply ? per_sh  : per_act;
      duty_nxt  = apply ? duty_sh : duty_act;

      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (start && !stop) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (tick) cnt_nxt = wrap ? '0 : cnt + ONE;
            if (stop) state_nxt = S_STOPPING;
         end
         S_STOPPING: begin
            if (tick) cnt_nxt = wrap ? '0 : cnt + ONE;
            if (wrap) state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      // Compare against the values that will be live after this edge so the
      // output never lags cnt, including on the edge a new duty is applied.
      pwm_nxt = PWM_IDLE;
      if ((state_nxt != S_IDLE) && (cnt_nxt < duty_nxt)) pwm_nxt = ~PWM_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         pwm_out    <= PWM_IDLE;
         period_end <= 1'b0;
         per_act    <= '1;
         duty_act   <= '0;
         per_sh     <= '0;
         duty_sh    <= '0;
         pending    <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         pwm_out    <= pwm_nxt;
         period_end <= wrap;
         per_act    <= per_nxt;
         duty_act   <= duty_nxt;
         if (xfer) begin
            per_sh  <= cfg_period;
            duty_sh <= cfg_duty;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
      end
   end

   assign cfg_ready = !pending;
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_pwm_gen_synch.sv
// Bench for pwm_gen_synch: directed scenarios followed by random stimulus,
// every cycle compared against an arithmetic reference model.
// Expected pwm level follows PWM_ACTIVE_LOW_EN when it is defined.

module tb_pwm_gen_synch;

   localparam int BITS = 8;

`ifdef PWM_ACTIVE_LOW_EN
   localparam logic ACT_LOW = 1'b1;
`else
   localparam logic ACT_LOW = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset, tick, start, stop, cfg_valid;
   logic            cfg_ready;
   logic [BITS-1:0] cfg_period, cfg_duty;
   logic            pwm_out;
   logic [BITS-1:0] cnt;
   logic            period_end, busy;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: mode 0 idle, 1 run, 2 stopping.
   int m_st, m_cnt, m_p, m_d, m_shp, m_shd;
   bit m_pend, m_pe;

   always #5 clk = ~clk;

   pwm_gen_synch #(.BITS(BITS)) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .start      (start),
      .stop       (stop),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .pwm_out    (pwm_out),
      .cnt        (cnt),
      .period_end (period_end),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic model_edge();
      bit run, wrap, xfer;
      int old_p;
      if (reset) begin
         m_st = 0; m_cnt = 0; m_p = (1 << BITS) - 1; m_d = 0;
         m_pend = 0; m_pe = 0;
      end else begin
         old_p = m_p;
         run   = (m_st != 0);
         wrap  = run && tick && (m_cnt == old_p);
         xfer  = cfg_valid && !m_pend;
         m_pe  = wrap;
         if (m_pend && (!run || wrap)) begin
            m_p = m_shp; m_d = m_shd; m_pend = 0;
         end else if (xfer) begin
            m_shp = int'(cfg_period); m_shd = int'(cfg_duty); m_pend = 1;
         end
         if (run && tick) m_cnt = (m_cnt + 1) % (old_p + 1);
         if (m_st == 0) begin
            m_cnt = 0;
            if (start && !stop) m_st = 1;
         end else if (m_st == 1) begin
            if (stop) m_st = 2;
         end else if (wrap) begin
            m_st = 0; m_cnt = 0;
         end
      end
   endtask

   task automatic check_all();
      bit on;
      on = (m_st != 0) && (m_cnt < m_d);
      chk("cnt", 32'(cnt), m_cnt);
      chk("pwm_out", 32'(pwm_out), 32'(on ^ ACT_LOW));
      chk("period_end", 32'(period_end), 32'(m_pe));
      chk("busy", 32'(busy), 32'(m_st != 0));
      chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
   endtask

   task automatic step(input bit r, input bit t, input bit s, input bit sp,
                       input bit v, input int p, input int d);
      reset = r; tick = t; start = s; stop = sp; cfg_valid = v;
      cfg_period = p[BITS-1:0]; cfg_duty = d[BITS-1:0];
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
   endtask

   // Offer a configuration and hold it until the block takes it.
   task automatic send_cfg(input int p, input int d, input bit t);
      int k;
      k = 0;
      while (m_pend && k < 400) begin
         step(0, t, 0, 0, 1, p, d);
         k++;
      end
      step(0, t, 0, 0, 1, p, d);
   endtask

   initial begin
      int k;
      reset = 1; tick = 0; start = 0; stop = 0; cfg_valid = 0;
      cfg_period = '0; cfg_duty = '0;

      // Reset state
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      chk("rst_cnt", 32'(cnt), 0);
      chk("rst_pwm", 32'(pwm_out), 32'(ACT_LOW));
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(cfg_ready), 1);
      chk("rst_pe", 32'(period_end), 0);

      // P=4 D=2 configured in IDLE, then run with tick every cycle
      send_cfg(4, 2, 1);
      chk("ready_idle_pending", 32'(cfg_ready), 0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("ready_idle_applied", 32'(cfg_ready), 1);
      step(0, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) step(0, 1, 0, 0, 0, 0, 0);
         chk("pat_cnt", 32'(cnt), i % 5);
         chk("pat_pwm", 32'(pwm_out), 32'(((i % 5) < 2) ^ ACT_LOW));
         chk("pat_pe", 32'(period_end), 32'((i % 5 == 0) && (i > 0)));
         chk("pat_busy", 32'(busy), 1);
      end

      // Mid-period reconfiguration to P=9 D=7
      run_ticks(2);
      send_cfg(9, 7, 1);
      chk("ready_drop", 32'(cfg_ready), 0);
      run_ticks(30);

      // P=3 D=1 with tick every third cycle
      send_cfg(3, 1, 1);
      for (int i = 0; i < 60; i++) step(0, (i % 3) == 0, 0, 0, 0, 0, 0);

      // Duty corner cases
      send_cfg(4, 0, 1);
      run_ticks(20);
      send_cfg(100, 200, 1);
      run_ticks(220);
      send_cfg(0, 0, 1);
      run_ticks(110);
      for (int i = 0; i < 4; i++) chk("p0_pe", 32'(period_end), 1);

      // stop at cnt=1 with P=4
      send_cfg(4, 2, 1);
      run_ticks(3);
      k = 0;
      while (m_cnt != 1 && k < 20) begin
         step(0, 1, 0, 0, 0, 0, 0);
         k++;
      end
      chk("stop_at_cnt1", 32'(cnt), 1);
      step(0, 1, 0, 1, 0, 0, 0);
      run_ticks(10);
      chk("stopped_busy", 32'(busy), 0);
      chk("stopped_pwm", 32'(pwm_out), 32'(ACT_LOW));
      step(0, 1, 1, 1, 0, 0, 0);
      chk("start_stop_idle", 32'(busy), 0);

      // Reset at cnt=3 with a pending configuration
      step(0, 1, 1, 0, 0, 0, 0);
      k = 0;
      while (m_cnt != 3 && k < 20) begin
         step(0, 1, 0, 0, 0, 0, 0);
         k++;
      end
      chk("rst_at_cnt3", 32'(cnt), 3);
      step(0, 0, 0, 0, 1, 9, 7);
      chk("rst_pending", 32'(cfg_ready), 0);
      step(1, 1, 0, 0, 0, 0, 0);
      chk("mid_rst_cnt", 32'(cnt), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_ready", 32'(cfg_ready), 1);
      step(0, 1, 1, 0, 0, 0, 0);
      run_ticks(270);

      // Random stimulus
      for (int i = 0; i < 2000; i++) begin
         int p, d;
         p = $urandom_range(0, 12);
         if ($urandom_range(0, 15) == 0) p = $urandom_range(0, 255);
         d = $urandom_range(0, 14);
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 3) == 0, p, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end

endmodule
